cpu_fetch_unit: RTL

- Instruction-fetch stage directly upstream of the CPU execution unit.
- Holds the PC and fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Presents a stable instruction register to the control unit and execution unit, then computes the next PC from the Branch, Jump, Zero and SEImm results of the executed instruction.
- Sequencing: one instruction in flight; the FSM alternates FETCH and EXEC.

---
 rtl/cpu_fetch_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/cpu_fetch_unit.sv
// -----------------------------------------------------------------------------
// cpu_fetch_unit
//   Instruction-fetch stage for a single-issue CPU.
//
//   This block holds the PC and fetches one 32-bit word per instruction from
//   instruction memory using a req/ack handshake. It then presents that word
//   to control and execute as a stable instruction register.
//
//   While EXEC is active, the next PC is chosen from the Jump, Branch, Zero
//   and SEImm results. Only one instruction is in flight at a time, so the
//   FSM simply alternates between FETCH and EXEC.
//
// Ports
//   clk, reset    : clock and synchronous active-high reset
//   IM_Addr       : instruction memory byte address (always the PC)
//   IM_Req        : fetch request, high for every FETCH cycle
//   IM_Ack        : memory returns IM_Data valid this cycle
//   IM_Data       : instruction word from memory
//   Branch, Jump  : decode of the current instruction (from control)
//   Zero          : ALU zero flag (from execute)
//   SEImm         : sign-extended immediate (from execute)
//   Stall         : hold the current instruction in EXEC
//   Instruction   : instruction register
//   Instr_Valid   : high for every EXEC cycle
//   PC, PC_Plus4  : current PC, and PC + 4
// -----------------------------------------------------------------------------
module cpu_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] IM_Addr,
    output logic        IM_Req,
    input  logic        IM_Ack,
    input  logic [31:0] IM_Data,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    input  logic [31:0] SEImm,
    input  logic        Stall,
    output logic [31:0] Instruction,
    output logic        Instr_Valid,
    output logic [31:0] PC,
    output logic [31:0] PC_Plus4
);

    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    // Next-PC selection. Jump has priority over Branch. A shift left by two
    // drops SEImm[31:30], which leaves {SEImm[29:0], 2'b00}. The adders wrap
    // modulo 2^32.
    always_comb begin
        next_pc = pc_plus4;
        if (Jump)
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        else if (Branch && Zero)
            next_pc = pc_plus4 + (SEImm << 2);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (IM_Ack) begin
                    instr_d = IM_Data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!Stall) begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // Reset has priority over everything at the edge. This abandons an
    // in-progress fetch (a coincident ack is dropped) and any pending PC update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RST;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Handshake outputs are pure state decodes, so no input reaches them
    // combinationally.
    assign IM_Req      = (state_q == ST_FETCH);
    assign Instr_Valid = (state_q == ST_EXEC);
    assign IM_Addr     = pc_q;
    assign PC          = pc_q;
    assign PC_Plus4    = pc_plus4;
    assign Instruction = instr_q;

endmodule
